// File: rtl/vga_sync_800x600_pkg.sv
// vga_sync_800x600 shared constants and types: default SVGA 800x600@60
// timing, counter and colour widths, and the delayed sync bundle.
package vga_sync_800x600_pkg;

    localparam int H_ACTIVE_D = 800;
    localparam int H_FP_D     = 40;
    localparam int H_SYNC_D   = 128;
    localparam int H_BP_D     = 88;
    localparam int V_ACTIVE_D = 600;
    localparam int V_FP_D     = 1;
    localparam int V_SYNC_D   = 4;
    localparam int V_BP_D     = 23;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int RGB_W  = 8;

    function automatic int total4(
        input int a,
        input int b,
        input int c,
        input int d
    );
        return a + b + c + d;
    endfunction

    localparam int H_TOTAL_D =
        total4(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
    localparam int V_TOTAL_D =
        total4(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);
    localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
    localparam int HS_END_D   = HS_START_D + H_SYNC_D;
    localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
    localparam int VS_END_D   = VS_START_D + V_SYNC_D;

    // Bit 0 is the active-area flag; the colour register taps it.
    typedef struct packed {
        logic hs;
        logic vs;
        logic valid;
    } sync_bits_t;

endpackage

// File: rtl/vga_sync_800x600_if.sv
// Video bus between the timing generator (master) and renderer/sink.
// Ports: pix_x/pix_y/pix_valid/frame_start out, rgb_in back, rgb_out/syncs/de out.
interface vga_sync_800x600_if;
    import vga_sync_800x600_pkg::*;

    logic [HCNT_W-1:0] pix_x;
    logic [VCNT_W-1:0] pix_y;
    logic              pix_valid;
    logic              frame_start;
    logic [RGB_W-1:0]  rgb_in;
    logic [RGB_W-1:0]  rgb_out;
    logic              hsync;
    logic              vsync;
    logic              de;

    modport master (
        output pix_x,
        output pix_y,
        output pix_valid,
        output frame_start,
        input  rgb_in,
        output rgb_out,
        output hsync,
        output vsync,
        output de
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        input  pix_valid,
        input  frame_start,
        output rgb_in,
        input  rgb_out,
        input  hsync,
        input  vsync,
        input  de
    );

endinterface

// File: rtl/vga_sync_800x600_sync_delay.sv
// W-bit wide, D-deep register chain with synchronous reset.
// Ports: i_clk, i_rst, i_d in; o_q = last stage, o_tap = one bit of stage TAP.
module vga_sync_800x600_sync_delay #(
    parameter int W       = 3,
    parameter int D       = 2,
    parameter int TAP     = 0,
    parameter int TAP_BIT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_tap
);

    generate
        if (D < 1 || TAP >= D || TAP_BIT >= W) begin : g_bad_cfg
            $error("sync_delay: bad depth/tap configuration");
        end
    endgenerate

    logic [W-1:0] r_sr [D];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < D; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < D; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q   = r_sr[D-1];
    assign o_tap = r_sr[TAP][TAP_BIT];

endmodule

// File: rtl/vga_sync_800x600.sv
// SVGA timing generator: h/v counters, stage-0 decode, 2-stage sync/colour pipe.
// Ports: i_clk (pixel clock), i_rst (sync, active high), io_vga (master modport).
module vga_sync_800x600
    import vga_sync_800x600_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input logic                 i_clk,
    input logic                 i_rst,
    vga_sync_800x600_if.master  io_vga
);

    localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > (1 << HCNT_W)) begin : g_h_range
            $error("vga_sync_800x600: H_TOTAL exceeds 11-bit counter");
        end
        if (V_TOTAL > (1 << VCNT_W)) begin : g_v_range
            $error("vga_sync_800x600: V_TOTAL exceeds 10-bit counter");
        end
    endgenerate

    // Decode bounds carry one extra bit so an end position equal to the
    // full counter range does not wrap to zero.
    localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W:0]   H_ACT    = 12'(H_ACTIVE);
    localparam logic [VCNT_W:0]   V_ACT    = 11'(V_ACTIVE);
    localparam logic [HCNT_W:0]   HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W:0]   HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W:0]   VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] r_h;
    logic [VCNT_W-1:0] r_v;
    logic [RGB_W-1:0]  r_rgb;

    logic [HCNT_W:0] w_hx;
    logic [VCNT_W:0] w_vx;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_s1_valid;
    sync_bits_t      w_s0;
    sync_bits_t      w_s2;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // v only moves on the h wrap, so both wrap on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_hx = {1'b0, r_h};
    assign w_vx = {1'b0, r_v};

    assign w_s0.valid = (w_hx < H_ACT) && (w_vx < V_ACT);
    assign w_s0.hs    = (w_hx >= HS_START) && (w_hx < HS_END);
    assign w_s0.vs    = (w_vx >= VS_START) && (w_vx < VS_END);

    vga_sync_800x600_sync_delay #(
        .W       (3),
        .D       (2),
        .TAP     (0),
        .TAP_BIT (0)
    ) u_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (w_s0),
        .o_q   (w_s2),
        .o_tap (w_s1_valid)
    );

    // Renderer colour arrives one cycle after its coordinate, i.e.
    // alongside the stage-1 valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_s1_valid ? io_vga.rgb_in : '0;
        end
    end

    assign io_vga.pix_x       = r_h;
    assign io_vga.pix_y       = r_v;
    assign io_vga.pix_valid   = w_s0.valid;
    assign io_vga.frame_start = (r_h == '0) && (r_v == '0) && !i_rst;
    assign io_vga.rgb_out     = r_rgb;
    assign io_vga.hsync       = (w_s2.hs == HS_POL);
    assign io_vga.vsync       = (w_s2.vs == VS_POL);
    assign io_vga.de          = w_s2.valid;

endmodule
